// File: rtl/mul_sequencer.sv
// Multi-cycle radix-2 shift-add MUL controller for the EX stage.
// Stalls the pipeline while iterating and pulses done_o with the low XLEN product bits.
module mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      ALUCtrl_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc, mcand, mplier, acc_nxt;
  logic [CW-1:0]   count;
  logic            start, last_iter;

  // One shift-add iteration; carries beyond XLEN bits are dropped.
  function automatic logic [XLEN-1:0] add_step(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] m,
                                               input logic            bit0);
    add_step = bit0 ? (a + m) : a;
  endfunction

  assign start     = valid_i && (ALUCtrl_i == ALU_MUL) && !flush_i;
  assign last_iter = (count == CW'(XLEN - 1));
  assign acc_nxt   = add_step(acc, mcand, mplier[0]);

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // DONE never looks at start, so the MUL still sitting in EX cannot restart.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = start;
        if (start) state_d = BUSY;
      end
      BUSY: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
        if (flush_i)        state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand  <= rs1_data_i;
            mplier <= rs2_data_i;
            acc    <= '0;
            count  <= '0;
          end
        end
        BUSY: begin
          if (!flush_i) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (last_iter) result_o <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed + randomized bench for mul_sequencer against a cycle-count/arithmetic reference model.
module tb_mul_sequencer;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            valid_i = 1'b0;
  logic [2:0]      ALUCtrl_i = 3'b000;
  logic            flush_i = 1'b0;
  logic [XLEN-1:0] rs1_data_i = '0;
  logic [XLEN-1:0] rs2_data_i = '0;
  logic            stall_o, busy_o, done_o;
  logic [XLEN-1:0] result_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  logic [XLEN-1:0] model_result = '0;

  mul_sequencer #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUCtrl_i(ALUCtrl_i),
    .flush_i(flush_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      chk({tag, "_stall"}, stall_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_result"}, result_o, model_result);
      next_cycle();
    end
  endtask

  // A MUL enters EX now; the pipeline holds it until done_o, then it leaves EX.
  task automatic run_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [63:0] prod;
    prod = {32'b0, a} * {32'b0, b};
    valid_i = 1'b1; ALUCtrl_i = 3'b101; flush_i = 1'b0;
    rs1_data_i = a; rs2_data_i = b;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk_i);
      chk("mul_stall", stall_o, 1);
      chk("mul_busy", busy_o, (k > 0) ? 1 : 0);
      chk("mul_done", done_o, 0);
      chk("mul_result_hold", result_o, model_result);
      next_cycle();
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
    end
    @(negedge clk_i);
    model_result = prod[XLEN-1:0];
    chk("done_pulse", done_o, 1);
    chk("done_stall", stall_o, 0);
    chk("done_busy", busy_o, 0);
    chk("done_result", result_o, model_result);
    last_done_cyc = cyc;
    next_cycle();
    valid_i = 1'b0;
    ALUCtrl_i = 3'($urandom_range(0, 7));
  endtask

  initial begin
    int d1;
    logic [2:0] codes [3];
    codes[0] = 3'b011; codes[1] = 3'b100; codes[2] = 3'b110;

    // Reset
    repeat (3) next_cycle();
    @(negedge clk_i);
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    next_cycle();
    rst_i = 1'b1;
    chk_idle("post_rst", 2);

    // Basic and wrap-around products
    run_mul(32'd7, 32'd6);
    chk_idle("after_7x6", 1);
    run_mul(32'hFFFF_FFFD, 32'd5);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul(32'h8000_0000, 32'd2);
    chk_idle("after_wrap", 1);

    // Ignored instructions
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; ALUCtrl_i = codes[i];
      rs1_data_i = $urandom; rs2_data_i = $urandom;
      chk_idle("non_mul", 2);
    end
    valid_i = 1'b0; ALUCtrl_i = 3'b101;
    chk_idle("mul_invalid", 3);

    // Back-to-back MULs
    run_mul(32'd3, 32'd4);
    d1 = last_done_cyc;
    run_mul(32'd5, 32'd5);
    chk("b2b_spacing", XLEN'(last_done_cyc - d1), 34);
    chk_idle("after_b2b", 1);

    // Flush mid-operation
    valid_i = 1'b1; ALUCtrl_i = 3'b101; rs1_data_i = 32'd9; rs2_data_i = 32'd9;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      chk("fl_stall", stall_o, 1);
      next_cycle();
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("fl_cycle_stall", stall_o, 1);
    next_cycle();
    flush_i = 1'b0; valid_i = 1'b0;
    chk_idle("after_flush", 40);

    // Flush together with start
    valid_i = 1'b1; ALUCtrl_i = 3'b101; flush_i = 1'b1;
    rs1_data_i = 32'd11; rs2_data_i = 32'd13;
    chk_idle("flush_start", 1);
    valid_i = 1'b0; flush_i = 1'b0;
    chk_idle("flush_start_after", 2);

    // Reset mid-operation
    valid_i = 1'b1; ALUCtrl_i = 3'b101; rs1_data_i = 32'd1234; rs2_data_i = 32'd77;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_i);
      chk("rm_stall", stall_o, 1);
      next_cycle();
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rm_busy_before", busy_o, 1);
    next_cycle();
    rst_i = 1'b1; valid_i = 1'b0;
    model_result = '0;
    chk_idle("rm_after", 2);
    run_mul(32'd2, 32'd3);
    chk_idle("after_2x3", 1);

    // Randomized operands
    for (int i = 0; i < 8; i++) begin
      run_mul($urandom, $urandom);
      if (i % 2 == 0) chk_idle("rand_gap", 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller for the MUL operation (ALU control code 3'b101) in the EX stage of the 5-stage RISC-V pipeline.
- On a valid MUL in EX it takes the operands, runs an iterative radix-2 shift-add multiply, and stalls the pipeline until the product is ready.
- It then releases the stall for one cycle with the low XLEN bits of the product. The single-cycle ALU handles every other ALU control code.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous active-low reset (sampled on clk_i rising edge; 0 = reset)
valid_i  input  1  EX stage holds a real instruction (not a bubble)
ALUCtrl_i  input  3  ALU control code of the EX instruction; 3'b101 = mul
flush_i  input  1  abort any in-flight multiply
rs1_data_i  input  XLEN  multiplicand (forwarded EX operand)
rs2_data_i  input  XLEN  multiplier (forwarded EX operand)
stall_o  output  1  hold PC, IF/ID, ID/EX; insert nothing into EX/MEM
busy_o  output  1  state == BUSY
done_o  output  1  one-cycle pulse: result_o valid for the EX/MEM write
result_o  output  XLEN  registered low XLEN bits of product

Behaviour:
- Reset (rst_i==0 at posedge): state=IDLE; acc, mcand, mplier, count=0; result_o=0; done_o=0; busy_o=0. stall_o=0 in the cycle after reset. Reset overrides every other input, including mid-operation.
- start = valid_i && ALUCtrl_i==3'b101 && !flush_i.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall_o = start (combinational, same cycle the MUL enters EX).
  - On start: mcand<=rs1_data_i, mplier<=rs2_data_i, acc<=0, count<=0, go to BUSY.
  - Otherwise stay in IDLE. Non-MUL codes and valid_i==0 are ignored.
- BUSY:
  - stall_o=1, busy_o=1.
  - Each cycle: if mplier[0], acc<=acc+mcand (mod 2^XLEN). Then mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - When count==XLEN-1 (last iteration): result_o<=final acc including this step's add, go to DONE.
  - If flush_i: go to IDLE, result_o unchanged, no done_o.
- DONE:
  - stall_o=0, done_o=1 for exactly this cycle. The pipeline advances and the MUL leaves EX.
  - Next state is always IDLE. The still-present MUL code in EX must not restart in DONE.
  - flush_i in DONE: done_o still 1. The pipeline is responsible for discarding the result.
- Latency: MUL in EX at cycle T → stall_o high T..T+XLEN (XLEN+1 cycles); done_o and result_o valid at T+XLEN+1.
- Back-to-back MUL: a new MUL in EX at T+XLEN+2 starts a fresh sequence. No lost or merged operations.
- Arithmetic:
  - Unsigned shift-add. The low XLEN bits equal the RISC-V MUL result for signed operands.
  - Overflow beyond XLEN bits is discarded.
  - count width is clog2(XLEN)+1.
- result_o holds its value between DONE pulses.
- Flush and start in the same IDLE cycle: flush wins, no stall.

Test Plan:
- Reset then ALUCtrl_i=3'b101, valid_i=1, rs1=7, rs2=6 at T → stall_o=1 for 33 cycles (T..T+32); done_o=1 and result_o=42 at T+33 only; busy_o=1 T+1..T+32.
- Signed/wrap: rs1=0xFFFFFFFD (-3), rs2=5 → result_o=0xFFFFFFF1. Then rs1=rs2=0xFFFFFFFF → result_o=0x00000001. Then rs1=0x80000000, rs2=2 → result_o=0x00000000.
- Non-MUL codes 3'b011/3'b100/3'b110 with valid_i=1, and MUL with valid_i=0 → stall_o=0, done_o=0, result_o unchanged.
- Two consecutive MULs (3×4, then 5×5) with the pipeline advancing on done_o → done pulses 34 cycles apart, result_o=12 then 25; no spurious restart in the DONE cycle.
- flush_i=1 at T+10 during 9×9 → state IDLE at T+11, stall_o=0 at T+11, no done_o, result_o keeps its previous value. flush_i together with start in IDLE → no stall.
- rst_i=0 at T+15 mid-multiply → next cycle all outputs 0, state IDLE. A following 2×3 completes normally with result_o=6.
